// File: rtl/booth_product_accumulator.sv
// Sums BLOCK_LEN signed Booth products per block and holds each block sum on a valid/ready output.
// Build option BOOTH_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACCUM | accepting products into acc; the last one of a block moves to HOLD
// HOLD  | block sum presented on out_sum/out_ovf until out_ready
module booth_product_accumulator #(
    parameter int PROD_W    = 4,
    parameter int ACC_W     = 8,
    parameter int BLOCK_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic               out_valid_d;
    logic [ACC_W-1:0]   out_sum_d;
    logic               out_ovf_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum_wrap;
    logic [ACC_W-1:0]   add_res;
    logic               add_ovf;

    assign prod_ext = ACC_W'($signed(in_product));
    assign sum_wrap = acc_q + prod_ext;
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_wrap[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow both operands share a sign, so acc's sign picks the rail.
    assign add_res = !add_ovf ? sum_wrap : (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX);
`else
    assign add_res = sum_wrap;
`endif

    assign in_ready = (state_q == ACCUM);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid;
        out_sum_d   = out_sum;
        out_ovf_d   = out_ovf;

        if (clr) begin
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            out_sum_d   = add_res;
                            out_ovf_d   = sticky_q | add_ovf;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            sticky_d    = 1'b0;
                            state_d     = HOLD;
                        end else begin
                            acc_d    = add_res;
                            cnt_d    = cnt_q + 1'b1;
                            sticky_d = sticky_q | add_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_ovf   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: default instance plus ACC_W=4 and BLOCK_LEN=1 variants.
module tb_booth_product_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_product = '0;

    logic       in_valid = 1'b0, in_ready, out_valid, out_ovf;
    logic [7:0] out_sum;

    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ovf4;
    logic [3:0] out_sum4;

    logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ovf1;
    logic [7:0] out_sum1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_product_accumulator #(.PROD_W(4), .ACC_W(8), .BLOCK_LEN(4)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    booth_product_accumulator #(.PROD_W(4), .ACC_W(4), .BLOCK_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_product(in_product),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_sum(out_sum4), .out_ovf(out_ovf4)
    );

    booth_product_accumulator #(.PROD_W(4), .ACC_W(8), .BLOCK_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_product(in_product),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_ovf(out_ovf1)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p);
        in_valid   = 1'b1;
        in_product = 4'(p);
        step();
        in_valid   = 1'b0;
    endtask

    int vals [12] = '{1, 2, 3, 4, -8, 7, -1, 0, 7, 7, 7, 7};
    int sums [3]  = '{10, -2, 28};

    initial begin
        int idx, blk, last_cyc;
        logic rdy;

        #12 rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum",   int'($signed(out_sum)), 0);
        check("rst_out_ovf",   int'(out_ovf), 0);
        check("rst_in_ready",  int'(in_ready), 1);
        step();

        // BLOCK_LEN=1 variant: single product goes straight to HOLD
        out_ready = 1'b0;
        in_valid1 = 1'b1; in_product = 4'(-5);
        step();
        in_valid1 = 1'b0;
        check("bl1_valid", int'(out_valid1), 1);
        check("bl1_sum",   int'($signed(out_sum1)), -5);
        check("bl1_ready", int'(in_ready1), 0);

        // ACC_W=4 overflow: 4+4 leaves the 4-bit range
        in_valid4 = 1'b1;
        in_product = 4'(4); step();
        in_product = 4'(4); step();
        in_product = 4'(0); step();
        in_product = 4'(0); step();
        in_valid4 = 1'b0;
        check("ovf4_valid", int'(out_valid4), 1);
`ifdef BOOTH_ACC_SAT_EN
        check("ovf4_sum", int'($signed(out_sum4)), 7);
`else
        check("ovf4_sum", int'($signed(out_sum4)), -8);
`endif
        check("ovf4_flag", int'(out_ovf4), 1);
        out_ready = 1'b1;
        step();
        check("ovf4_drain", int'(out_valid4), 0);
        check("bl1_drain",  int'(out_valid1), 0);

        // Test 1: 1,2,0,1 -> 4, one-cycle out_valid
        send(1); send(2); send(0);
        check("t1_not_yet", int'(out_valid), 0);
        send(1);
        check("t1_valid", int'(out_valid), 1);
        check("t1_sum",   int'($signed(out_sum)), 4);
        check("t1_ovf",   int'(out_ovf), 0);
        check("t1_hold_ready", int'(in_ready), 0);
        step();
        check("t1_one_cycle", int'(out_valid), 0);
        check("t1_ready_back", int'(in_ready), 1);

        // Test 2: held output with back-pressure; extra products ignored
        out_ready = 1'b0;
        send(-1); send(-1); send(-2); send(1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_product = 4'(5);
            step();
            check("t2_valid", int'(out_valid), 1);
            check("t2_sum",   int'($signed(out_sum)), -3);
            check("t2_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("t2_drain", int'(out_valid), 0);

        // Test 4: clr discards the partial block and the same-cycle product
        send(3); send(3);
        clr = 1'b1; in_valid = 1'b1; in_product = 4'(3);
        step();
        clr = 1'b0; in_valid = 1'b0;
        check("t4_clr_valid", int'(out_valid), 0);
        send(1); send(1); send(1); send(1);
        check("t4_valid", int'(out_valid), 1);
        check("t4_sum",   int'($signed(out_sum)), 4);
        step();

        // Test 5: async reset mid-block and mid-HOLD
        send(2); send(2);
        rst = 1'b1;
        #1;
        check("t5_mid_valid", int'(out_valid), 0);
        check("t5_mid_ready", int'(in_ready), 1);
        rst = 1'b0;
        step();
        out_ready = 1'b0;
        send(2); send(2); send(2); send(2);
        check("t5_hold_sum", int'($signed(out_sum)), 8);
        rst = 1'b1;
        #1;
        check("t5_hold_valid", int'(out_valid), 0);
        check("t5_hold_sumclr", int'($signed(out_sum)), 0);
        check("t5_hold_ready", int'(in_ready), 1);
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        send(1); send(2); send(3); send(-1);
        check("t5_after_valid", int'(out_valid), 1);
        check("t5_after_sum",   int'($signed(out_sum)), 5);
        step();

        // Test 6: streaming with in_valid and out_ready held high
        idx = 0; blk = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid   = (idx < 12);
            in_product = 4'(vals[(idx < 12) ? idx : 11]);
            rdy = in_ready;
            step();
            if (rdy && in_valid) idx++;
            if (out_valid) begin
                if (blk < 3) check("t6_sum", int'($signed(out_sum)), sums[blk]);
                if (blk > 0) check("t6_period", cyc - last_cyc, 5);
                last_cyc = cyc;
                blk++;
            end
        end
        in_valid = 1'b0;
        check("t6_blocks", blk, 3);
        check("t6_consumed", idx, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
